core_ldst_router: RTL and testbench
===================================

Name: core_ldst_router

Overview:
- Sits directly downstream of the core pipeline's load/store port.
- Routes each core load/store to either the data memory bus or the IO bus, using a programmable IO start address.
- Tracks the single outstanding transaction and returns that side's response to the core as one registered completion.
- Shared request fields (order/rw/addr/data) drive both buses; only the REQ strobes are steered.

Parameters:
none

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  synchronous active-high reset
iIO_STARTADDR_VALID  in  1  load IO start address
iIO_STARTADDR  in  32  lowest IO-mapped address
iLDST_REQ  in  1  core request
oLDST_BUSY  out  1  core must hold request
iLDST_ORDER  in  2  00 byte, 01 half, 10 word
iLDST_RW  in  1  0 write, 1 read
iLDST_TID  in  14  task id
iLDST_MMUMOD  in  2  MMU mode
iLDST_PDT  in  32  page directory
iLDST_ADDR  in  32  address
iLDST_DATA  in  32  write data
oLDST_VALID  out  1  completion, 1-cycle pulse
oLDST_PAGEFAULT  out  1  completion faulted
oLDST_DATA  out  32  read data
oDATA_REQ  out  1  data memory request
iDATA_LOCK  in  1  data side cannot accept
oDATA_TID  out  14  iLDST_TID pass-through
oDATA_MMUMOD  out  2  pass-through
oDATA_PDT  out  32  pass-through
iDATA_VALID  in  1  data response
iDATA_PAGEFAULT  in  1  data fault
iDATA_DATA  in  64  data doubleword
oIO_REQ  out  1  IO request
iIO_BUSY  in  1  IO side cannot accept
iIO_VALID  in  1  IO response
iIO_DATA  in  32  IO read data
oOUT_ORDER  out  2  shared order
oOUT_RW  out  1  shared rw
oOUT_ADDR  out  32  shared address
oOUT_DATA  out  32  shared write data

Behaviour:
- Interface is fixed: one clock iCLOCK; reset iRESET_SYNC is synchronous and active-high.
- Reset state:
  - FSM in IDLE; start address = 0, start-address-valid = 0.
  - oLDST_VALID, oLDST_PAGEFAULT, oLDST_DATA = 0; latched addr[2] = 0.
  - oDATA_REQ = oIO_REQ = 0.
- Start address register:
  - Loads iIO_STARTADDR on any cycle with iIO_STARTADDR_VALID, in any state.
  - Valid flag is sticky until reset.
  - A change never affects an in-flight transaction.
- Routing: target = IO when iLDST_ADDR >= start address (unsigned 32-bit compare), else DATA.
- oLDST_BUSY (combinational) = !startaddr_valid || state != IDLE || (target DATA && iDATA_LOCK) || (target IO && iIO_BUSY).
- Accept condition: IDLE && iLDST_REQ && !oLDST_BUSY.
- On accept, same cycle (combinational):
  - Exactly one of oDATA_REQ / oIO_REQ is 1.
  - oOUT_*/oDATA_TID/MMUMOD/PDT mirror the iLDST_* inputs.
  - All other cycles: both REQs 0, mirrored fields don't-care.
- On accept, at the clock edge: latch iLDST_ADDR[2]; go to DATA_WAIT or IO_WAIT.
- FSM (2-bit):
  - IDLE -> DATA_WAIT / IO_WAIT on accept.
  - DATA_WAIT -> IDLE on iDATA_VALID.
  - IO_WAIT -> IDLE on iIO_VALID.
- Completion (registered, 1 cycle after the response valid):
  - oLDST_VALID = 1.
  - DATA: oLDST_DATA = latched addr[2] ? iDATA_DATA[63:32] : iDATA_DATA[31:0]; oLDST_PAGEFAULT = iDATA_PAGEFAULT.
  - IO: oLDST_DATA = iIO_DATA; oLDST_PAGEFAULT = 0.
  - oLDST_VALID self-clears the next cycle; oLDST_DATA holds its value.
- Writes also complete with exactly one oLDST_VALID.
- A new request may be accepted in the same cycle oLDST_VALID is high.
- Ignored inputs: a response valid from the non-waiting side, and any response valid in IDLE.
- Simultaneous iDATA_VALID and iIO_VALID: only the waiting side is honoured.
- Reset mid-transaction: back to IDLE, pending completion dropped; the start address must be reloaded.

Test Plan:
- Request before start address is loaded: no REQ issued, oLDST_BUSY=1 throughout.
- Start address = 0x8000_0000; read word at 0x0000_1004; iDATA_DATA = 0xAAAA_BBBB_CCCC_DDDD two cycles later -> one oDATA_REQ pulse; oLDST_VALID the cycle after iDATA_VALID; oLDST_DATA = 0xAAAA_BBBB.
- Write to 0x8000_0000 (boundary, data 0x1234_5678) -> oIO_REQ=1, oOUT_RW=0, oOUT_DATA=0x1234_5678; iIO_VALID -> oLDST_VALID=1, oLDST_PAGEFAULT=0.
- iDATA_LOCK=1 for 3 cycles with a data-target request -> oLDST_BUSY=1 and oDATA_REQ=0 for 3 cycles; request issued on cycle 4.
- In DATA_WAIT: spurious iIO_VALID, then iDATA_VALID with iDATA_PAGEFAULT=1 -> single completion, oLDST_PAGEFAULT=1; back-to-back request accepted in the completion cycle.
- iRESET_SYNC asserted in IO_WAIT, then iIO_VALID arrives -> no oLDST_VALID; oLDST_BUSY=1 until the start address is reloaded.

Source files
------------

// File: rtl/core_ldst_router.sv
// core_ldst_router: steers each core load/store to the data-memory bus or the IO bus
// and returns the single outstanding response to the core as one registered completion.
module core_ldst_router (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iIO_STARTADDR_VALID,
    input  logic [31:0] iIO_STARTADDR,
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic [1:0]  iLDST_ORDER,
    input  logic        iLDST_RW,
    input  logic [13:0] iLDST_TID,
    input  logic [1:0]  iLDST_MMUMOD,
    input  logic [31:0] iLDST_PDT,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    output logic        oLDST_VALID,
    output logic        oLDST_PAGEFAULT,
    output logic [31:0] oLDST_DATA,
    output logic        oDATA_REQ,
    input  logic        iDATA_LOCK,
    output logic [13:0] oDATA_TID,
    output logic [1:0]  oDATA_MMUMOD,
    output logic [31:0] oDATA_PDT,
    input  logic        iDATA_VALID,
    input  logic        iDATA_PAGEFAULT,
    input  logic [63:0] iDATA_DATA,
    output logic        oIO_REQ,
    input  logic        iIO_BUSY,
    input  logic        iIO_VALID,
    input  logic [31:0] iIO_DATA,
    output logic [1:0]  oOUT_ORDER,
    output logic        oOUT_RW,
    output logic [31:0] oOUT_ADDR,
    output logic [31:0] oOUT_DATA
);

    // state     | meaning
    // IDLE      | nothing outstanding, a request may be accepted
    // DATA_WAIT | data-memory request issued, waiting for iDATA_VALID
    // IO_WAIT   | IO request issued, waiting for iIO_VALID
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_WAIT = 2'd1,
        IO_WAIT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] startaddr;
    logic        startaddr_valid;
    logic        addr_bit2;
    logic        target_io;
    logic        accept;

    assign target_io = (iLDST_ADDR >= startaddr);

    // Shared request fields go to both buses unconditionally; only the strobes are steered.
    assign oOUT_ORDER   = iLDST_ORDER;
    assign oOUT_RW      = iLDST_RW;
    assign oOUT_ADDR    = iLDST_ADDR;
    assign oOUT_DATA    = iLDST_DATA;
    assign oDATA_TID    = iLDST_TID;
    assign oDATA_MMUMOD = iLDST_MMUMOD;
    assign oDATA_PDT    = iLDST_PDT;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = target_io ? IO_WAIT : DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (iDATA_VALID) begin
                    state_next = IDLE;
                end
            end
            IO_WAIT: begin
                if (iIO_VALID) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oLDST_BUSY = !startaddr_valid || (state != IDLE) ||
                     (!target_io && iDATA_LOCK) || (target_io && iIO_BUSY);
        accept     = (state == IDLE) && iLDST_REQ && !oLDST_BUSY;
        oDATA_REQ  = accept && !target_io;
        oIO_REQ    = accept && target_io;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            startaddr       <= 32'h0;
            startaddr_valid <= 1'b0;
        end else if (iIO_STARTADDR_VALID) begin
            startaddr       <= iIO_STARTADDR;
            startaddr_valid <= 1'b1;
        end
    end

    // Completion is registered; the non-waiting side's valid is ignored by construction.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oLDST_VALID     <= 1'b0;
            oLDST_PAGEFAULT <= 1'b0;
            oLDST_DATA      <= 32'h0;
            addr_bit2       <= 1'b0;
        end else begin
            oLDST_VALID <= 1'b0;
            if (accept) begin
                addr_bit2 <= iLDST_ADDR[2];
            end
            if ((state == DATA_WAIT) && iDATA_VALID) begin
                oLDST_VALID     <= 1'b1;
                oLDST_PAGEFAULT <= iDATA_PAGEFAULT;
                oLDST_DATA      <= addr_bit2 ? iDATA_DATA[63:32] : iDATA_DATA[31:0];
            end else if ((state == IO_WAIT) && iIO_VALID) begin
                oLDST_VALID     <= 1'b1;
                oLDST_PAGEFAULT <= 1'b0;
                oLDST_DATA      <= iIO_DATA;
            end
        end
    end

endmodule

// File: tb/tb_core_ldst_router.sv
// Bench for core_ldst_router: a vector table, hand sequences for the multi-cycle corners,
// and random transactions checked against a transaction-level routing model.
module tb_core_ldst_router;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sa_valid, req, rw, busy, lvalid, lpf, dreq, dlock, dvalid, dpf;
    logic        ioreq, iobusy, iovalid, orw;
    logic [31:0] sa, pdt, addr, wdata, ldata, dpdt, iodata, oaddr, odata;
    logic [1:0]  order, mmumod, dmmu, oorder;
    logic [13:0] tid, dtid;
    logic [63:0] ddata;

    int vectors = 0;
    int miscompares = 0;

    core_ldst_router dut (
        .iCLOCK(clk), .iRESET_SYNC(rst),
        .iIO_STARTADDR_VALID(sa_valid), .iIO_STARTADDR(sa),
        .iLDST_REQ(req), .oLDST_BUSY(busy), .iLDST_ORDER(order), .iLDST_RW(rw),
        .iLDST_TID(tid), .iLDST_MMUMOD(mmumod), .iLDST_PDT(pdt), .iLDST_ADDR(addr),
        .iLDST_DATA(wdata), .oLDST_VALID(lvalid), .oLDST_PAGEFAULT(lpf), .oLDST_DATA(ldata),
        .oDATA_REQ(dreq), .iDATA_LOCK(dlock), .oDATA_TID(dtid), .oDATA_MMUMOD(dmmu),
        .oDATA_PDT(dpdt), .iDATA_VALID(dvalid), .iDATA_PAGEFAULT(dpf), .iDATA_DATA(ddata),
        .oIO_REQ(ioreq), .iIO_BUSY(iobusy), .iIO_VALID(iovalid), .iIO_DATA(iodata),
        .oOUT_ORDER(oorder), .oOUT_RW(orw), .oOUT_ADDR(oaddr), .oOUT_DATA(odata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        dlock;
        logic        iobusy;
        logic [63:0] rdata;
        logic        pf;
        logic [31:0] iodata;
        logic        exp_busy;
        logic        exp_dreq;
        logic        exp_ioreq;
        logic [31:0] exp_data;
        logic        exp_pf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; dvalid = 1'b0; iovalid = 1'b0; sa_valid = 1'b0;
        dlock = 1'b0; iobusy = 1'b0; dpf = 1'b0;
    endtask

    task automatic load_sa(input logic [31:0] v);
        sa = v;
        sa_valid = 1'b1;
        tick();
        sa_valid = 1'b0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic r, input logic [31:0] d);
        req = 1'b1; addr = a; rw = r; wdata = d;
        order = 2'b10; tid = 14'($urandom); mmumod = 2'($urandom); pdt = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] sa_model, a, rio, exp_data;
        logic [63:0] rdata;
        logic        tgt_io, exp_busy, accepted, rpf, exp_pf;

        tbl[0] = '{32'h0000_1004, 1'b1, 32'h0, 1'b0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 32'hAAAA_BBBB, 1'b0};
        tbl[1] = '{32'h0000_1000, 1'b1, 32'h0, 1'b0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 32'hCCCC_DDDD, 1'b0};
        tbl[2] = '{32'h8000_0000, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 64'h0, 1'b0, 32'hDEAD_0001,
                   1'b0, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0};
        tbl[3] = '{32'h7FFF_FFFC, 1'b1, 32'h0, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 1'b1, 32'h0,
                   1'b0, 1'b1, 1'b0, 32'h1111_2222, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'hCAFE_F00D,
                   1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tbl[5] = '{32'h0000_0010, 1'b1, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[6] = '{32'h9000_0000, 1'b1, 32'h0, 1'b0, 1'b1, 64'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[7] = '{32'h9000_0000, 1'b1, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h55AA_55AA,
                   1'b0, 1'b0, 1'b1, 32'h55AA_55AA, 1'b0};
        tbl[8] = '{32'h0000_0020, 1'b0, 32'hFEED_BEEF, 1'b0, 1'b1, 64'h9999_8888_7777_6666, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 32'h7777_6666, 1'b0};

        rst = 1'b1;
        idle_inputs();
        sa = 32'h0; order = 2'b0; rw = 1'b0; tid = 14'h0; mmumod = 2'b0; pdt = 32'h0;
        addr = 32'h0; wdata = 32'h0; ddata = 64'h0; iodata = 32'h0;
        tick();
        tick();
        chk("rst_valid", 64'(lvalid), 64'd0);
        chk("rst_pf", 64'(lpf), 64'd0);
        chk("rst_data", 64'(ldata), 64'd0);
        chk("rst_dreq", 64'(dreq), 64'd0);
        chk("rst_ioreq", 64'(ioreq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;

        // No start address yet: everything stays blocked
        set_req(32'h0000_1004, 1'b1, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("nosa_busy", 64'(busy), 64'd1);
            chk("nosa_dreq", 64'(dreq), 64'd0);
            chk("nosa_ioreq", 64'(ioreq), 64'd0);
            tick();
        end
        req = 1'b0;
        load_sa(32'h8000_0000);

        for (int i = 0; i < 9; i++) begin
            set_req(tbl[i].addr, tbl[i].rw, tbl[i].wdata);
            dlock = tbl[i].dlock;
            iobusy = tbl[i].iobusy;
            @(negedge clk);
            chk("tbl_busy", 64'(busy), 64'(tbl[i].exp_busy));
            chk("tbl_dreq", 64'(dreq), 64'(tbl[i].exp_dreq));
            chk("tbl_ioreq", 64'(ioreq), 64'(tbl[i].exp_ioreq));
            if (!tbl[i].exp_busy) begin
                chk("tbl_out_addr", 64'(oaddr), 64'(tbl[i].addr));
                chk("tbl_out_rw", 64'(orw), 64'(tbl[i].rw));
                chk("tbl_out_data", 64'(odata), 64'(tbl[i].wdata));
                chk("tbl_tid", 64'(dtid), 64'(tid));
            end
            tick();
            req = 1'b0; dlock = 1'b0; iobusy = 1'b0;
            if (!tbl[i].exp_busy) begin
                chk("tbl_wait_busy", 64'(busy), 64'd1);
                if (tbl[i].exp_dreq) begin
                    dvalid = 1'b1; ddata = tbl[i].rdata; dpf = tbl[i].pf;
                end else begin
                    iovalid = 1'b1; iodata = tbl[i].iodata;
                end
                tick();
                dvalid = 1'b0; iovalid = 1'b0; dpf = 1'b0;
                chk("tbl_valid", 64'(lvalid), 64'd1);
                chk("tbl_data", 64'(ldata), 64'(tbl[i].exp_data));
                chk("tbl_pf", 64'(lpf), 64'(tbl[i].exp_pf));
                tick();
                chk("tbl_valid_clear", 64'(lvalid), 64'd0);
                chk("tbl_data_hold", 64'(ldata), 64'(tbl[i].exp_data));
            end
        end

        // Data lock held 3 cycles, then issue; response two cycles after the request
        set_req(32'h0000_1004, 1'b1, 32'h0);
        dlock = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("lock_busy", 64'(busy), 64'd1);
            chk("lock_dreq", 64'(dreq), 64'd0);
            tick();
        end
        dlock = 1'b0;
        @(negedge clk);
        chk("lock_busy_rel", 64'(busy), 64'd0);
        chk("lock_dreq_rel", 64'(dreq), 64'd1);
        tick();
        req = 1'b0;
        tick();
        chk("lock_no_early", 64'(lvalid), 64'd0);
        dvalid = 1'b1; ddata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        dvalid = 1'b0;
        chk("lock_valid", 64'(lvalid), 64'd1);
        chk("lock_data", 64'(ldata), 64'hAAAA_BBBB);
        tick();
        chk("lock_valid_clear", 64'(lvalid), 64'd0);

        // Spurious IO valid in DATA_WAIT, faulted data completion, back-to-back IO request
        set_req(32'h0000_2004, 1'b1, 32'h0);
        @(negedge clk);
        chk("spur_dreq", 64'(dreq), 64'd1);
        tick();
        req = 1'b0;
        iovalid = 1'b1; iodata = 32'hBAD0_BAD0;
        tick();
        iovalid = 1'b0;
        chk("spur_ignored", 64'(lvalid), 64'd0);
        dvalid = 1'b1; dpf = 1'b1; ddata = 64'h0123_4567_89AB_CDEF;
        tick();
        dvalid = 1'b0; dpf = 1'b0;
        chk("pf_valid", 64'(lvalid), 64'd1);
        chk("pf_flag", 64'(lpf), 64'd1);
        chk("pf_data", 64'(ldata), 64'h0123_4567);
        set_req(32'h8000_0010, 1'b0, 32'h5555_0000);
        @(negedge clk);
        chk("b2b_busy", 64'(busy), 64'd0);
        chk("b2b_ioreq", 64'(ioreq), 64'd1);
        chk("b2b_dreq", 64'(dreq), 64'd0);
        tick();
        req = 1'b0;
        chk("b2b_valid_clear", 64'(lvalid), 64'd0);
        chk("b2b_data_hold", 64'(ldata), 64'h0123_4567);
        dvalid = 1'b1; dpf = 1'b1; ddata = 64'hFFFF_FFFF_FFFF_FFFF;
        iovalid = 1'b1; iodata = 32'h0F0F_0F0F;
        tick();
        dvalid = 1'b0; dpf = 1'b0; iovalid = 1'b0;
        chk("both_valid", 64'(lvalid), 64'd1);
        chk("both_pf", 64'(lpf), 64'd0);
        chk("both_data", 64'(ldata), 64'h0F0F_0F0F);
        tick();
        chk("both_single", 64'(lvalid), 64'd0);

        // Reset while in IO_WAIT drops the completion and the start address
        set_req(32'h9000_0000, 1'b1, 32'h0);
        @(negedge clk);
        chk("rmid_ioreq", 64'(ioreq), 64'd1);
        tick();
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iovalid = 1'b1; iodata = 32'h0000_0077;
        tick();
        iovalid = 1'b0;
        chk("rmid_no_valid", 64'(lvalid), 64'd0);
        set_req(32'h0000_0040, 1'b1, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rmid_busy", 64'(busy), 64'd1);
            chk("rmid_dreq", 64'(dreq), 64'd0);
            chk("rmid_ioreq", 64'(ioreq), 64'd0);
            tick();
        end
        load_sa(32'h8000_0000);
        @(negedge clk);
        chk("rmid_reload_busy", 64'(busy), 64'd0);
        chk("rmid_reload_dreq", 64'(dreq), 64'd1);
        tick();
        req = 1'b0;
        dvalid = 1'b1; ddata = 64'h0000_0001_0000_0002;
        tick();
        dvalid = 1'b0;
        chk("rmid_valid", 64'(lvalid), 64'd1);
        chk("rmid_data", 64'(ldata), 64'h0000_0002);
        tick();

        // Random transactions against a routing model
        sa_model = 32'h8000_0000;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                sa_model = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                load_sa(sa_model);
            end
            case ($urandom_range(0, 3))
                0: a = sa_model;
                1: a = sa_model - 32'd1;
                default: a = $urandom;
            endcase
            set_req(a, 1'($urandom_range(0, 1)), $urandom);
            tgt_io = (a >= sa_model);
            accepted = 1'b0;
            for (int c = 0; c < 20 && !accepted; c++) begin
                dlock  = (c < 19) && ($urandom_range(0, 2) == 0);
                iobusy = (c < 19) && ($urandom_range(0, 2) == 0);
                @(negedge clk);
                exp_busy = tgt_io ? iobusy : dlock;
                chk("rnd_busy", 64'(busy), 64'(exp_busy));
                chk("rnd_dreq", 64'(dreq), 64'(!exp_busy && !tgt_io));
                chk("rnd_ioreq", 64'(ioreq), 64'(!exp_busy && tgt_io));
                if (!exp_busy) begin
                    chk("rnd_addr", 64'(oaddr), 64'(a));
                end
                tick();
                accepted = !exp_busy;
            end
            req = 1'b0; dlock = 1'b0; iobusy = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                ddata[63:32] = $urandom;
                ddata[31:0] = $urandom;
                iodata = $urandom;
                if (tgt_io) dvalid = 1'($urandom_range(0, 1));
                else iovalid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) begin
                    sa_model = $urandom;
                    sa = sa_model;
                    sa_valid = 1'b1;
                end
                tick();
                dvalid = 1'b0; iovalid = 1'b0; sa_valid = 1'b0;
                chk("rnd_early_valid", 64'(lvalid), 64'd0);
            end
            rdata[63:32] = $urandom;
            rdata[31:0] = $urandom;
            rpf = 1'($urandom_range(0, 1));
            rio = $urandom;
            ddata = rdata; iodata = rio; dpf = rpf;
            if (tgt_io) begin
                iovalid = 1'b1;
                dvalid = 1'($urandom_range(0, 1));
            end else begin
                dvalid = 1'b1;
                iovalid = 1'($urandom_range(0, 1));
            end
            exp_data = tgt_io ? rio : (a[2] ? rdata[63:32] : rdata[31:0]);
            exp_pf = tgt_io ? 1'b0 : rpf;
            tick();
            dvalid = 1'b0; iovalid = 1'b0; dpf = 1'b0;
            chk("rnd_valid", 64'(lvalid), 64'd1);
            chk("rnd_data", 64'(ldata), 64'(exp_data));
            chk("rnd_pf", 64'(lpf), 64'(exp_pf));
            tick();
            chk("rnd_valid_clear", 64'(lvalid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
